// File: rtl/pc_sequencer.sv
// Fetch/redirect controller for the program counter block: walks each instruction
// through FETCH and EXEC, picks the PC redirect and keeps a small return-address stack.
module pc_sequencer #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned RAS_PTR_W = $clog2(RAS_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [XLEN-1:0]      pc_count,
  output logic                 pc_load,
  output logic [XLEN-1:0]      pc_load_val,
  output logic                 pc_alu_in,
  output logic [XLEN-1:0]      pc_alu_val,
  output logic                 imem_req,
  output logic [XLEN-1:0]      imem_addr,
  input  logic                 imem_ack,
  input  logic                 jmp_valid,
  input  logic                 call_valid,
  input  logic [XLEN-1:0]      jmp_target,
  input  logic                 ret_valid,
  input  logic                 br_valid,
  input  logic                 br_taken,
  input  logic [XLEN-1:0]      br_target,
  input  logic                 halt,
  input  logic                 resume,
  output logic [1:0]           state,
  output logic [RAS_PTR_W-1:0] ras_count,
  output logic                 ras_err
);

  localparam int unsigned          RasIdxW = $clog2(RAS_DEPTH);
  localparam logic [RAS_PTR_W-1:0] RasFull = RAS_PTR_W'(RAS_DEPTH);

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StExec  = 2'd1,
    StHalt  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [RAS_PTR_W-1:0] ras_count_q, ras_count_d;
  logic [XLEN-1:0]      ras_q [RAS_DEPTH];
  logic [XLEN-1:0]      ras_d [RAS_DEPTH];

  logic                 ras_empty;
  logic                 ras_full;
  logic [RasIdxW-1:0]   top_idx;
  logic [RasIdxW-1:0]   push_idx;

  assign ras_empty = (ras_count_q == '0);
  assign ras_full  = (ras_count_q == RasFull);
  assign top_idx   = RasIdxW'(ras_count_q - RAS_PTR_W'(1));
  assign push_idx  = RasIdxW'(ras_count_q);

  assign state     = state_q;
  assign ras_count = ras_count_q;

  always_comb begin
    state_d     = state_q;
    ras_count_d = ras_count_q;
    ras_d       = ras_q;
    pc_load     = 1'b0;
    pc_load_val = pc_count;
    pc_alu_in   = 1'b0;
    pc_alu_val  = br_target;
    imem_req    = 1'b0;
    imem_addr   = pc_count;
    ras_err     = 1'b0;

    unique case (state_q)
      StFetch: begin
        // The counter free-runs, so holding the PC means reloading it.
        imem_req = 1'b1;
        pc_load  = 1'b1;
        if (imem_ack) begin
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = StFetch;
        if (halt) begin
          pc_load = 1'b1;
          state_d = StHalt;
        end else if (ret_valid) begin
          if (!ras_empty) begin
            pc_load     = 1'b1;
            pc_load_val = ras_q[top_idx];
            ras_count_d = ras_count_q - RAS_PTR_W'(1);
          end else begin
            ras_err = 1'b1;
          end
        end else if (call_valid) begin
          pc_load     = 1'b1;
          pc_load_val = jmp_target;
          if (!ras_full) begin
            ras_d[push_idx] = pc_count + XLEN'(1);
            ras_count_d     = ras_count_q + RAS_PTR_W'(1);
          end else begin
            ras_err = 1'b1;
          end
        end else if (jmp_valid) begin
          pc_load     = 1'b1;
          pc_load_val = jmp_target;
        end else if (br_valid && br_taken) begin
          pc_alu_in = 1'b1;
        end
      end
      StHalt: begin
        pc_load = 1'b1;
        if (resume) begin
          state_d = StFetch;
        end
      end
      default: begin
        state_d = StFetch;
      end
    endcase

    if (reset) begin
      pc_load   = 1'b0;
      pc_alu_in = 1'b0;
      imem_req  = 1'b0;
      ras_err   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StFetch;
      ras_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ras_count_q <= ras_count_d;
    end
  end

  // Stack contents are don't-care after reset; only the count is cleared.
  always_ff @(posedge clk) begin
    ras_q <= ras_d;
  end

  assert property (@(posedge clk) !(pc_load && pc_alu_in));
  assert property (@(posedge clk) ras_count_q <= RasFull);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a behavioural PC counter plus an
// instruction-level reference model (next-PC rules and a queue-based return stack).
module tb_pc_sequencer;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned RAS_DEPTH = 4;
  localparam int unsigned RAS_PTR_W = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [XLEN-1:0]      pc_count;
  logic                 pc_load;
  logic [XLEN-1:0]      pc_load_val;
  logic                 pc_alu_in;
  logic [XLEN-1:0]      pc_alu_val;
  logic                 imem_req;
  logic [XLEN-1:0]      imem_addr;
  logic                 imem_ack;
  logic                 jmp_valid;
  logic                 call_valid;
  logic [XLEN-1:0]      jmp_target;
  logic                 ret_valid;
  logic                 br_valid;
  logic                 br_taken;
  logic [XLEN-1:0]      br_target;
  logic                 halt;
  logic                 resume;
  logic [1:0]           state;
  logic [RAS_PTR_W-1:0] ras_count;
  logic                 ras_err;

  pc_sequencer #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH),
    .RAS_PTR_W (RAS_PTR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_count    (pc_count),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .pc_alu_in   (pc_alu_in),
    .pc_alu_val  (pc_alu_val),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .jmp_valid   (jmp_valid),
    .call_valid  (call_valid),
    .jmp_target  (jmp_target),
    .ret_valid   (ret_valid),
    .br_valid    (br_valid),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .halt        (halt),
    .resume      (resume),
    .state       (state),
    .ras_count   (ras_count),
    .ras_err     (ras_err)
  );

  always #5 clk = ~clk;

  // Program-counter block: load wins over alu_in, otherwise increment.
  always @(posedge clk) begin
    if (reset)          pc_count <= '0;
    else if (pc_load)   pc_count <= pc_load_val;
    else if (pc_alu_in) pc_count <= pc_alu_val;
    else                pc_count <= pc_count + 32'd1;
  end

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [XLEN-1:0] mdl_pc;
  logic [XLEN-1:0] mdl_ras [$];
  logic [XLEN-1:0] exp_pc;
  logic            exp_load, exp_alu, exp_err, exp_halt;

  logic [XLEN-1:0] obs_addr, obs_pc;
  int unsigned     obs_req;
  logic            obs_hold;
  logic            obs_load, obs_alu, obs_err;
  logic [1:0]      obs_state;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_ack   = 1'b0;
    jmp_valid  = 1'b0;
    call_valid = 1'b0;
    ret_valid  = 1'b0;
    br_valid   = 1'b0;
    br_taken   = 1'b0;
    halt       = 1'b0;
    resume     = 1'b0;
    jmp_target = '0;
    br_target  = '0;
  endtask

  // Instruction-level reference: decides the next PC and stack effect of one EXEC.
  task automatic model_exec();
    logic [XLEN-1:0] nxt;
    exp_pc   = mdl_pc;
    exp_load = 1'b0;
    exp_alu  = 1'b0;
    exp_err  = 1'b0;
    exp_halt = 1'b0;
    nxt      = mdl_pc + 32'd1;
    if (halt) begin
      exp_load = 1'b1;
      exp_halt = 1'b1;
      nxt      = mdl_pc;
    end else if (ret_valid) begin
      if (mdl_ras.size() > 0) begin
        exp_load = 1'b1;
        nxt      = mdl_ras.pop_back();
      end else begin
        exp_err = 1'b1;
      end
    end else if (call_valid) begin
      exp_load = 1'b1;
      nxt      = jmp_target;
      if (mdl_ras.size() < int'(RAS_DEPTH)) mdl_ras.push_back(mdl_pc + 32'd1);
      else exp_err = 1'b1;
    end else if (jmp_valid) begin
      exp_load = 1'b1;
      nxt      = jmp_target;
    end else if (br_valid && br_taken) begin
      exp_alu = 1'b1;
      nxt     = br_target;
    end
    mdl_pc = nxt;
  endtask

  // Drives one FETCH phase with the ack after `delay` wait cycles; records observations.
  task automatic fetch(input int delay);
    obs_req  = 0;
    obs_hold = 1'b1;
    for (int i = 0; i <= delay; i++) begin
      imem_ack = (i == delay);
      #1;
      if (i == 0) obs_addr = imem_addr;
      if (imem_req) obs_req++;
      if (!(pc_load && !pc_alu_in && pc_load_val == obs_addr && pc_count == obs_addr))
        obs_hold = 1'b0;
      tick();
    end
    imem_ack = 1'b0;
  endtask

  // One EXEC cycle with whatever redirect inputs the caller has set.
  task automatic exec_cycle();
    model_exec();
    #1;
    obs_load  = pc_load;
    obs_alu   = pc_alu_in;
    obs_err   = ras_err;
    obs_state = state;
    obs_pc    = pc_count;
    tick();
    clear_inputs();
  endtask

  task automatic goto_pc(input logic [XLEN-1:0] target);
    fetch(0);
    jmp_valid  = 1'b1;
    jmp_target = target;
    exec_cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    imem_ack   = 1'b1;
    jmp_valid  = 1'b1;
    jmp_target = 32'h55;
    halt       = 1'b1;
    resume     = 1'b1;
    br_valid   = 1'b1;
    br_taken   = 1'b1;
    #1;
    n_checks++;
    if ({pc_load, pc_alu_in, imem_req, ras_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 0000", {pc_load, pc_alu_in, imem_req, ras_err});
    end
    tick();
    n_checks++;
    if (state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d required 0", state);
    end
    n_checks++;
    if (ras_count !== '0) begin
      n_fail++;
      $display("FAIL reset_ras_count: got %0d required 0", ras_count);
    end
    n_checks++;
    if (pc_count !== '0) begin
      n_fail++;
      $display("FAIL reset_pc: got %h required 0", pc_count);
    end
    clear_inputs();
    reset  = 1'b0;
    mdl_pc = '0;
    mdl_ras.delete();
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      fetch(0);
      n_checks++;
      if (obs_addr !== XLEN'(i) || obs_addr !== mdl_pc) begin
        n_fail++;
        $display("FAIL seq_fetch_addr: got %h required %h", obs_addr, XLEN'(i));
      end
      n_checks++;
      if (obs_hold !== 1'b1 || obs_req != 1) begin
        n_fail++;
        $display("FAIL seq_fetch_hold: hold %b req_cycles %0d required 1 and 1", obs_hold, obs_req);
      end
      exec_cycle();
      n_checks++;
      if (obs_state !== 2'd1 || obs_pc !== exp_pc || obs_load !== 1'b0 || obs_alu !== 1'b0) begin
        n_fail++;
        $display("FAIL seq_exec: state %0d pc %h load %b alu %b required 1 %h 0 0",
                 obs_state, obs_pc, obs_load, obs_alu, exp_pc);
      end
    end
  endtask

  task automatic test_ack_delay();
    goto_pc(32'd5);
    fetch(3);
    n_checks++;
    if (obs_addr !== 32'd5 || obs_req != 4 || obs_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_delay: addr %h req_cycles %0d hold %b required 5 4 1",
               obs_addr, obs_req, obs_hold);
    end
    exec_cycle();
    fetch(0);
    n_checks++;
    if (obs_addr !== 32'd6) begin
      n_fail++;
      $display("FAIL ack_delay_next: got %h required 6", obs_addr);
    end
    exec_cycle();
  endtask

  task automatic test_branch();
    goto_pc(32'h10);
    fetch(0);
    br_valid  = 1'b1;
    br_taken  = 1'b1;
    br_target = 32'h40;
    exec_cycle();
    n_checks++;
    if (obs_alu !== 1'b1 || obs_load !== 1'b0) begin
      n_fail++;
      $display("FAIL br_taken_ctl: alu %b load %b required 1 0", obs_alu, obs_load);
    end
    fetch(0);
    n_checks++;
    if (obs_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL br_taken_target: got %h required 40", obs_addr);
    end
    exec_cycle();
    goto_pc(32'h10);
    fetch(0);
    br_valid  = 1'b1;
    br_taken  = 1'b0;
    br_target = 32'h40;
    exec_cycle();
    fetch(0);
    n_checks++;
    if (obs_addr !== 32'h11 || obs_alu !== 1'b0) begin
      n_fail++;
      $display("FAIL br_not_taken: addr %h alu %b required 11 0", obs_addr, obs_alu);
    end
    exec_cycle();
    goto_pc(32'hFFFF_FFFF);
    fetch(0);
    exec_cycle();
    fetch(0);
    n_checks++;
    if (obs_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL pc_wrap: got %h required 0", obs_addr);
    end
    exec_cycle();
  endtask

  task automatic test_call_ret();
    goto_pc(32'h20);
    fetch(0);
    call_valid = 1'b1;
    jmp_target = 32'h100;
    exec_cycle();
    n_checks++;
    if (ras_count !== 3'd1) begin
      n_fail++;
      $display("FAIL call_ras_count: got %0d required 1", ras_count);
    end
    for (int i = 0; i < 4; i++) begin
      fetch(0);
      n_checks++;
      if (obs_addr !== 32'h100 + XLEN'(i)) begin
        n_fail++;
        $display("FAIL call_body: got %h required %h", obs_addr, 32'h100 + XLEN'(i));
      end
      exec_cycle();
    end
    fetch(0);
    ret_valid = 1'b1;
    exec_cycle();
    n_checks++;
    if (ras_count !== 3'd0 || obs_load !== 1'b1) begin
      n_fail++;
      $display("FAIL ret_ras: count %0d load %b required 0 1", ras_count, obs_load);
    end
    fetch(0);
    n_checks++;
    if (obs_addr !== 32'h21) begin
      n_fail++;
      $display("FAIL ret_target: got %h required 21", obs_addr);
    end
    exec_cycle();
  endtask

  task automatic test_call_ret_same_cycle();
    goto_pc(32'h200);
    fetch(0);
    call_valid = 1'b1;
    jmp_target = 32'h300;
    exec_cycle();
    fetch(0);
    call_valid = 1'b1;
    ret_valid  = 1'b1;
    jmp_target = 32'h500;
    exec_cycle();
    fetch(0);
    n_checks++;
    if (obs_addr !== 32'h201 || ras_count !== 3'd0) begin
      n_fail++;
      $display("FAIL call_ret_same: addr %h count %0d required 201 0", obs_addr, ras_count);
    end
    exec_cycle();
  endtask

  task automatic test_ras_overflow();
    for (int i = 0; i < 5; i++) begin
      fetch(0);
      call_valid = 1'b1;
      jmp_target = $urandom & 32'h00FF_FFF0;
      exec_cycle();
      n_checks++;
      if (obs_err !== (i == 4) || obs_err !== exp_err) begin
        n_fail++;
        $display("FAIL ovf_err[%0d]: got %b required %b", i, obs_err, (i == 4));
      end
    end
    n_checks++;
    if (ras_count !== 3'd4) begin
      n_fail++;
      $display("FAIL ovf_count: got %0d required 4", ras_count);
    end
    for (int i = 0; i < 5; i++) begin
      fetch(0);
      n_checks++;
      if (obs_addr !== mdl_pc) begin
        n_fail++;
        $display("FAIL ret_order[%0d]: got %h required %h", i, obs_addr, mdl_pc);
      end
      ret_valid = 1'b1;
      exec_cycle();
      n_checks++;
      if (obs_err !== (i == 4) || obs_load !== (i != 4)) begin
        n_fail++;
        $display("FAIL udf_err[%0d]: err %b load %b required %b %b", i, obs_err, obs_load,
                 (i == 4), (i != 4));
      end
    end
    fetch(0);
    n_checks++;
    if (obs_addr !== mdl_pc || ras_count !== 3'd0) begin
      n_fail++;
      $display("FAIL udf_seq: addr %h count %0d required %h 0", obs_addr, ras_count, mdl_pc);
    end
    exec_cycle();
  endtask

  task automatic test_halt();
    int bad;
    bad = 0;
    goto_pc(32'd7);
    fetch(0);
    halt       = 1'b1;
    jmp_valid  = 1'b1;
    jmp_target = 32'h99;
    exec_cycle();
    n_checks++;
    if (obs_load !== 1'b1 || state !== 2'd2) begin
      n_fail++;
      $display("FAIL halt_enter: load %b state %0d required 1 2", obs_load, state);
    end
    for (int i = 0; i < 10; i++) begin
      halt       = 1'b1;
      imem_ack   = 1'($urandom_range(0, 1));
      jmp_valid  = 1'($urandom_range(0, 1));
      br_valid   = 1'b1;
      br_taken   = 1'b1;
      jmp_target = $urandom;
      br_target  = $urandom;
      #1;
      if (pc_count !== 32'd7 || state !== 2'd2 || imem_req !== 1'b0 || pc_load !== 1'b1) bad++;
      tick();
    end
    clear_inputs();
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL halt_hold: got %0d bad cycles required 0", bad);
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    n_checks++;
    if (state !== 2'd0) begin
      n_fail++;
      $display("FAIL halt_resume: got state %0d required 0", state);
    end
    fetch(0);
    n_checks++;
    if (obs_addr !== 32'd7) begin
      n_fail++;
      $display("FAIL halt_refetch: got %h required 7", obs_addr);
    end
    exec_cycle();
  endtask

  task automatic test_reset_mid_fetch();
    fetch(0);
    call_valid = 1'b1;
    jmp_target = 32'h40;
    exec_cycle();
    tick();
    reset    = 1'b1;
    imem_ack = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_req: got %b required 0", imem_req);
    end
    tick();
    reset    = 1'b0;
    imem_ack = 1'b0;
    mdl_pc   = '0;
    mdl_ras.delete();
    n_checks++;
    if (state !== 2'd0 || ras_count !== '0 || pc_count !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_state: state %0d count %0d pc %h required 0 0 0",
               state, ras_count, pc_count);
    end
    fetch(0);
    n_checks++;
    if (state !== 2'd1 || obs_addr !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_mid_ack: state %0d addr %h required 1 0", state, obs_addr);
    end
    exec_cycle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 150; n++) begin
      fetch(int'($urandom_range(0, 2)));
      n_checks++;
      if (obs_addr !== mdl_pc || obs_hold !== 1'b1) begin
        n_fail++;
        $display("FAIL rnd_fetch[%0d]: addr %h hold %b required %h 1", n, obs_addr, obs_hold, mdl_pc);
      end
      ret_valid  = ($urandom_range(0, 3) == 0);
      call_valid = ($urandom_range(0, 3) == 0);
      jmp_valid  = ($urandom_range(0, 4) == 0);
      br_valid   = ($urandom_range(0, 2) == 0);
      br_taken   = 1'($urandom_range(0, 1));
      jmp_target = $urandom;
      br_target  = $urandom;
      exec_cycle();
      n_checks++;
      if ({obs_load, obs_alu, obs_err} !== {exp_load, exp_alu, exp_err}) begin
        n_fail++;
        $display("FAIL rnd_exec[%0d]: load/alu/err %b required %b", n,
                 {obs_load, obs_alu, obs_err}, {exp_load, exp_alu, exp_err});
      end
      n_checks++;
      if (ras_count !== RAS_PTR_W'(mdl_ras.size())) begin
        n_fail++;
        $display("FAIL rnd_ras[%0d]: got %0d required %0d", n, ras_count, mdl_ras.size());
      end
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_sequential();
    test_ack_delay();
    test_branch();
    test_call_ret();
    test_call_ret_same_cycle();
    test_ras_overflow();
    test_halt();
    test_reset_mid_fetch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch/redirect controller that drives the program-counter block's `load` / `alu_in` controls.
- Sequences each instruction through FETCH (instruction-memory handshake) and EXEC (PC update).
- Resolves jump, branch, call and return redirects by fixed priority; holds a small return-address stack (RAS).
- Stalls the PC by reloading its current value, since the counter increments every cycle otherwise.

Parameters:
- XLEN, 32, PC and address width.
- RAS_DEPTH, 4, return-address stack entries (power of 2, >= 2).
- RAS_PTR_W, $clog2(RAS_DEPTH)+1, width of ras_count.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- pc_count  input  XLEN  current PC from counter.
- pc_load  output  1  to counter `load`.
- pc_load_val  output  XLEN  to counter `load_val`.
- pc_alu_in  output  1  to counter `alu_in`.
- pc_alu_val  output  XLEN  to counter `alu_val`.
- imem_req  output  1  instruction fetch request.
- imem_addr  output  XLEN  fetch address.
- imem_ack  input  1  fetch complete (instruction valid this cycle).
- jmp_valid  input  1  absolute jump in EXEC.
- call_valid  input  1  call in EXEC, target = jmp_target.
- jmp_target  input  XLEN  jump/call target.
- ret_valid  input  1  return in EXEC.
- br_valid  input  1  conditional branch in EXEC.
- br_taken  input  1  branch outcome, qualified by br_valid.
- br_target  input  XLEN  ALU-computed branch target.
- halt  input  1  halt request, sampled in EXEC.
- resume  input  1  leave HALT.
- state  output  2  FETCH=0, EXEC=1, HALT=2.
- ras_count  output  RAS_PTR_W  valid RAS entries.
- ras_err  output  1  one-cycle pulse on RAS overflow/underflow.

Behaviour:
- Reset: state=FETCH, ras_count=0, RAS contents don't-care, ras_err=0. While reset is high, all control outputs=0 and imem_req=0.
- Control outputs are combinational from state and inputs.
- Defaults: pc_load_val=pc_count, pc_alu_val=br_target, imem_addr=pc_count.
- FETCH:
  - imem_req=1, pc_load=1 with load_val=pc_count (PC hold).
  - imem_ack=1 -> EXEC next cycle; else stay in FETCH.
  - Zero-wait ack gives FETCH->EXEC->FETCH, i.e. 2 cycles per instruction.
- EXEC: lasts exactly one cycle, imem_req=0. Priority, first match wins:
  1. halt: pc_load=1, val=pc_count; next state HALT. No RAS change. Other redirects ignored.
  2. ret_valid:
     - RAS non-empty: pc_load=1, val=RAS top; pop.
     - RAS empty: no redirect (PC increments), ras_err=1.
  3. call_valid: pc_load=1, val=jmp_target; push pc_count+1 (mod 2^XLEN).
     - RAS full: target still taken, push dropped, ras_err=1.
  4. jmp_valid: pc_load=1, val=jmp_target.
  5. br_valid & br_taken: pc_alu_in=1, alu_val=br_target, pc_load=0.
  6. Otherwise: pc_load=0, pc_alu_in=0; counter increments (wrap 0xFFFFFFFF->0).
  - Next state FETCH, except after halt.
- pc_load and pc_alu_in are never both 1 in any cycle.
- HALT:
  - pc_load=1, val=pc_count; imem_req=0.
  - resume=1 -> FETCH next cycle; halt ignored in HALT.
- Inputs and events:
  - imem_ack outside FETCH is ignored.
  - Redirect inputs outside EXEC are ignored.
  - Simultaneous call+ret: ret wins, no push.
- RAS is LIFO; ras_count saturates at 0 and RAS_DEPTH.
- Reset mid-FETCH: imem_req drops in the reset cycle; the outstanding ack is ignored unless it arrives in the first FETCH after reset, where it is accepted.
- state output is 2'd3 only on illegal encoding; the illegal state recovers to FETCH next cycle.

Test Plan:
- Reset, then ack every FETCH, no redirects -> pc_count 0,1,2,3 on successive EXEC cycles; imem_addr matches; pc_load=1 only in FETCH.
- Ack delayed 3 cycles at PC=5 -> imem_req high 4 cycles, pc_load=1 with val=5 throughout, PC=6 after EXEC.
- EXEC at PC=0x10 with br_valid=1, br_taken=1, br_target=0x40 -> pc_alu_in=1, next fetch at 0x40. Same with br_taken=0 -> next fetch at 0x11.
- call at PC=0x20 to 0x100, then ret at 0x104 -> ras_count 1 then 0, fetch sequence 0x100...0x104, 0x21.
- 5 calls with RAS_DEPTH=4 -> ras_err pulse on 5th, ras_count=4. 5 rets -> returns in LIFO order, 5th has ras_err=1 and sequential PC.
- halt in EXEC at PC=7 -> HALT, PC held at 7 for 10 cycles. resume -> FETCH of 7. Reset asserted mid-FETCH -> state=FETCH, ras_count=0, PC=0.
